// File: rtl/irq_pending_arb_pkg.sv
// Shared interrupt/CSR types and constants for the machine-level interrupt front end.
// Bit positions follow the mip/mie layout; cause codes set bit 5 to mark interrupts.
package irq_pending_arb_pkg;

   typedef struct packed {
      logic        irq_software;
      logic        irq_timer;
      logic        irq_external;
      logic [14:0] irq_fast;
   } irqs_t;

   typedef enum logic [5:0] {
      EXC_CAUSE_INSN_ADDR_MISA = 6'h00,
      EXC_CAUSE_IRQ_SOFTWARE_M = 6'h23,
      EXC_CAUSE_IRQ_TIMER_M    = 6'h27,
      EXC_CAUSE_IRQ_EXTERNAL_M = 6'h2B,
      EXC_CAUSE_IRQ_FAST_0     = 6'h30,
      EXC_CAUSE_IRQ_FAST_14    = 6'h3E,
      EXC_CAUSE_IRQ_NM         = 6'h3F
   } exc_cause_e;

   typedef enum logic [1:0] {
      CSR_OP_READ,
      CSR_OP_WRITE,
      CSR_OP_SET,
      CSR_OP_CLEAR
   } csr_op_e;

   typedef enum logic [11:0] {
      CSR_MIE = 12'h304,
      CSR_MIP = 12'h344
   } csr_num_e;

   localparam int unsigned CSR_MSIX_BIT      = 3;
   localparam int unsigned CSR_MTIX_BIT      = 7;
   localparam int unsigned CSR_MEIX_BIT      = 11;
   localparam int unsigned CSR_MFIX_BIT_LOW  = 16;
   localparam int unsigned CSR_MFIX_BIT_HIGH = 30;

   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_REQ,
      IRQ_HOLD
   } irq_arb_state_e;

   localparam logic [31:0] CSR_MIE_MASK = 32'h7FFF_0888;

   // Fast interrupt i is reported as cause {1'b1, 16+i}.
   function automatic exc_cause_e fast_cause(input int unsigned idx);
      return exc_cause_e'({1'b1, 5'(CSR_MFIX_BIT_LOW + idx)});
   endfunction

endpackage

// File: rtl/irq_pending_arb_prio.sv
// Fixed-priority encoder: NMI, external, software, timer, then fast 0 upwards.
// Lower-priority candidates are assigned first so that higher ones overwrite them.
module irq_prio_enc
   import irq_pending_arb_pkg::*;
#(
   parameter int unsigned NUM_FAST = 15
) (
   input  logic [31:0] eligible_i,
   input  logic        nmi_pending_i,
   output logic        any_o,
   output exc_cause_e  cause_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      any_o   = nmi_pending_i | (|eligible_i);
      cause_o = EXC_CAUSE_INSN_ADDR_MISA;
      for (int i = NUM_FAST - 1; i >= 0; i--) begin
         if (eligible_i[CSR_MFIX_BIT_LOW + i]) cause_o = fast_cause(i);
      end
      if (eligible_i[CSR_MTIX_BIT]) cause_o = EXC_CAUSE_IRQ_TIMER_M;
      if (eligible_i[CSR_MSIX_BIT]) cause_o = EXC_CAUSE_IRQ_SOFTWARE_M;
      if (eligible_i[CSR_MEIX_BIT]) cause_o = EXC_CAUSE_IRQ_EXTERNAL_M;
      if (nmi_pending_i)            cause_o = EXC_CAUSE_IRQ_NM;
   end

endmodule

// File: rtl/irq_pending_arb.sv
// Interrupt front end: mip/mie CSRs, NMI edge latch, and a req/ack handshake that
// presents one frozen cause to the trap stage.
module irq_pending_arb
   import irq_pending_arb_pkg::*;
#(
   parameter int unsigned NUM_FAST = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  irqs_t       irqs_i,
   input  logic        irq_nm_i,
   input  logic        mstatus_mie_i,
   input  logic        csr_we_i,
   input  csr_op_e     csr_op_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   output logic [31:0] csr_rdata_o,
   output logic        irq_req_o,
   output exc_cause_e  irq_cause_o,
   input  logic        irq_ack_i
);

   logic [31:0]    mip_q, mip_d, mie_q, mie_d, eligible;
   logic           nm_q, nmi_pending_q, nmi_set, nmi_clear;
   logic           enc_any, latched_eligible;
   exc_cause_e     enc_cause, cause_q, cause_d;
   irq_arb_state_e state_q, state_d;

   always_comb begin
      mip_d               = '0;
      mip_d[CSR_MSIX_BIT] = irqs_i.irq_software;
      mip_d[CSR_MTIX_BIT] = irqs_i.irq_timer;
      mip_d[CSR_MEIX_BIT] = irqs_i.irq_external;
      for (int i = 0; i < NUM_FAST; i++) mip_d[CSR_MFIX_BIT_LOW + i] = irqs_i.irq_fast[i];
   end

   always_comb begin
      mie_d = mie_q;
      if (csr_we_i && csr_addr_i == CSR_MIE) begin
         unique case (csr_op_i)
            CSR_OP_WRITE: mie_d = csr_wdata_i;
            CSR_OP_SET:   mie_d = mie_q | csr_wdata_i;
            CSR_OP_CLEAR: mie_d = mie_q & ~csr_wdata_i;
            default:      mie_d = mie_q;
         endcase
      end
      mie_d = mie_d & CSR_MIE_MASK;
   end

   always_comb begin
      csr_rdata_o = '0;
      if (csr_addr_i == CSR_MIE)      csr_rdata_o = mie_q;
      else if (csr_addr_i == CSR_MIP) csr_rdata_o = mip_q;
   end

   assign eligible         = mip_q & mie_q & {32{mstatus_mie_i}};
   assign nmi_set          = irq_nm_i & ~nm_q;
   assign nmi_clear        = (state_q == IRQ_REQ) && irq_ack_i && (cause_q == EXC_CAUSE_IRQ_NM);
   // The low five cause bits are the mip bit index of the latched source.
   assign latched_eligible = eligible[cause_q[4:0]];

   irq_prio_enc #(.NUM_FAST(NUM_FAST)) u_prio_enc (
      .eligible_i    (eligible),
      .nmi_pending_i (nmi_pending_q),
      .any_o         (enc_any),
      .cause_o       (enc_cause)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         IRQ_IDLE: begin
            if (enc_any) begin
               state_d = IRQ_REQ;
               cause_d = enc_cause;
            end
         end
         IRQ_REQ: begin
            // Ack beats withdraw; an NMI request is never withdrawn.
            if (irq_ack_i)                                                   state_d = IRQ_HOLD;
            else if (cause_q != EXC_CAUSE_IRQ_NM && !latched_eligible)       state_d = IRQ_IDLE;
         end
         IRQ_HOLD: state_d = IRQ_IDLE;
         default:  state_d = IRQ_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         mip_q         <= '0;
         mie_q         <= '0;
         nm_q          <= 1'b0;
         nmi_pending_q <= 1'b0;
         state_q       <= IRQ_IDLE;
         cause_q       <= EXC_CAUSE_INSN_ADDR_MISA;
         irq_req_o     <= 1'b0;
      end else begin
         mip_q         <= mip_d;
         mie_q         <= mie_d;
         nm_q          <= irq_nm_i;
         nmi_pending_q <= nmi_set | (nmi_pending_q & ~nmi_clear);
         state_q       <= state_d;
         cause_q       <= cause_d;
         irq_req_o     <= (state_d == IRQ_REQ);
      end
   end

   assign irq_cause_o = cause_q;

endmodule

// File: tb/tb_irq_pending_arb.sv
// Self-checking bench for irq_pending_arb: directed scenarios plus a randomized run
// compared cycle by cycle against a priority-list reference model.
module tb_irq_pending_arb;
   import irq_pending_arb_pkg::*;

   localparam int unsigned TB_NUM_FAST = 15;

   logic        clk = 1'b0;
   logic        rst;
   irqs_t       irqs;
   logic        irq_nm, mstatus_mie, csr_we, irq_ack;
   csr_op_e     csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata;
   logic        irq_req;
   exc_cause_e  irq_cause;

   int vectors = 0;
   int miscompares = 0;

   irq_pending_arb #(.NUM_FAST(TB_NUM_FAST)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .irqs_i        (irqs),
      .irq_nm_i      (irq_nm),
      .mstatus_mie_i (mstatus_mie),
      .csr_we_i      (csr_we),
      .csr_op_i      (csr_op),
      .csr_addr_i    (csr_addr),
      .csr_wdata_i   (csr_wdata),
      .csr_rdata_o   (csr_rdata),
      .irq_req_o     (irq_req),
      .irq_cause_o   (irq_cause),
      .irq_ack_i     (irq_ack)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Priority order expressed as a list of mip bit indices; 31 stands for the NMI.
   int prio_order [19] = '{31, 11, 3, 7, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30};

   logic [31:0] m_mip = '0, m_mie = '0, n_mip, n_mie;
   logic        m_nmi = 1'b0, m_nm_prev = 1'b0, n_nmi, n_nm_prev;
   int          m_phase = 0, n_phase;        // 0 idle, 1 requesting, 2 hold
   logic [5:0]  m_cause = 6'h00, n_cause;

   function automatic logic [31:0] model_capture(input irqs_t r);
      logic [31:0] v;
      v = '0;
      v[3]  = r.irq_software;
      v[7]  = r.irq_timer;
      v[11] = r.irq_external;
      for (int i = 0; i < int'(TB_NUM_FAST); i++) v[16 + i] = r.irq_fast[i];
      return v;
   endfunction

   function automatic logic [5:0] model_winner(input logic [31:0] elig, input logic nmi);
      logic [31:0] cand;
      cand     = elig;
      cand[31] = nmi;
      foreach (prio_order[k]) if (cand[prio_order[k]]) return 6'(32 + prio_order[k]);
      return 6'h00;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [11:0] addr);
      if (addr == 12'h304) return m_mie;
      if (addr == 12'h344) return m_mip;
      return 32'h0;
   endfunction

   task automatic model_eval();
      logic [31:0] elig;
      logic [5:0]  win;
      logic        clr;
      elig  = m_mip & m_mie & {32{mstatus_mie}};
      win   = model_winner(elig, m_nmi);
      clr   = 1'b0;
      n_mip = model_capture(irqs);
      n_mie = m_mie;
      if (csr_we && csr_addr == 12'h304) begin
         if (csr_op == CSR_OP_WRITE) n_mie = csr_wdata;
         if (csr_op == CSR_OP_SET)   n_mie = m_mie | csr_wdata;
         if (csr_op == CSR_OP_CLEAR) n_mie = m_mie & ~csr_wdata;
      end
      n_mie   = n_mie & 32'h7FFF_0888;
      n_phase = m_phase;
      n_cause = m_cause;
      if (m_phase == 0) begin
         if (win != 6'h00) begin n_phase = 1; n_cause = win; end
      end else if (m_phase == 1) begin
         if (irq_ack) begin n_phase = 2; clr = (m_cause == 6'h3F); end
         else if (m_cause != 6'h3F && !elig[m_cause[4:0]]) n_phase = 0;
      end else begin
         n_phase = 0;
      end
      n_nmi     = (irq_nm && !m_nm_prev) || (m_nmi && !clr);
      n_nm_prev = irq_nm;
      if (rst) begin
         n_mip = '0; n_mie = '0; n_nmi = 1'b0; n_nm_prev = 1'b0; n_phase = 0; n_cause = 6'h00;
      end
   endtask

   // Advance the clock one cycle with the model tracking the DUT; returns 2 ns after the edge.
   task automatic tick();
      model_eval();
      @(posedge clk);
      m_mip = n_mip; m_mie = n_mie; m_nmi = n_nmi; m_nm_prev = n_nm_prev;
      m_phase = n_phase; m_cause = n_cause;
      #2;
   endtask

   task automatic csr_access(input csr_op_e op, input logic [11:0] addr, input logic [31:0] wdata);
      csr_we = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wdata;
      tick();
      csr_we = 1'b0; csr_op = CSR_OP_READ;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; irqs = '1;
      tick();
      csr_addr = 12'h344; #1;
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %0b want 0", irq_req); end
      vectors++; if (irq_cause !== 6'h00) begin miscompares++; $display("FAIL reset_cause: got %h want 00", irq_cause); end
      vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_mip: got %h want 0", csr_rdata); end
      csr_addr = 12'h304; #1;
      vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_mie: got %h want 0", csr_rdata); end
      rst = 1'b0; irqs = '0;
      tick();
   endtask

   task automatic test_csr_mask();
      csr_access(CSR_OP_SET, 12'h304, 32'hFFFF_FFFF);
      csr_addr = 12'h304; #1;
      vectors++; if (csr_rdata !== 32'h7FFF_0888) begin miscompares++; $display("FAIL mie_set: got %h want 7fff0888", csr_rdata); end
      csr_we = 1'b1; csr_op = CSR_OP_CLEAR; csr_wdata = 32'h0000_0080; #1;
      vectors++; if (csr_rdata !== 32'h7FFF_0888) begin miscompares++; $display("FAIL mie_prewrite: got %h want 7fff0888", csr_rdata); end
      tick();
      csr_we = 1'b0; csr_op = CSR_OP_READ; #1;
      vectors++; if (csr_rdata !== 32'h7FFF_0808) begin miscompares++; $display("FAIL mie_clear: got %h want 7fff0808", csr_rdata); end
      csr_access(CSR_OP_WRITE, 12'h344, 32'hFFFF_FFFF);
      irqs.irq_software = 1'b1; irqs.irq_fast[14] = 1'b1;
      tick();
      csr_addr = 12'h304; #1;
      vectors++; if (csr_rdata !== 32'h7FFF_0808) begin miscompares++; $display("FAIL mip_write_ignored: mie got %h want 7fff0808", csr_rdata); end
      csr_addr = 12'h344; #1;
      vectors++; if (csr_rdata !== 32'h4000_0008) begin miscompares++; $display("FAIL mip_read: got %h want 40000008", csr_rdata); end
      csr_addr = 12'h300; #1;
      vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL other_addr: got %h want 0", csr_rdata); end
      irqs = '0;
      tick(); tick();
   endtask

   task automatic test_external();
      mstatus_mie = 1'b1;
      csr_access(CSR_OP_WRITE, 12'h304, 32'h0000_0800);
      irqs.irq_external = 1'b1;
      tick();
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ext_n1: req got %0b want 0", irq_req); end
      tick();
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL ext_n2: req got %0b want 1", irq_req); end
      vectors++; if (irq_cause !== 6'h2B) begin miscompares++; $display("FAIL ext_cause: got %h want 2b", irq_cause); end
      tick(); tick();
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL ext_held: req got %0b want 1", irq_req); end
      irq_ack = 1'b1; irqs.irq_external = 1'b0;
      tick();
      irq_ack = 1'b0;
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ext_hold: req got %0b want 0", irq_req); end
      tick(); tick();
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ext_idle: req got %0b want 0", irq_req); end
   endtask

   task automatic test_priority();
      csr_access(CSR_OP_WRITE, 12'h304, 32'h7FFF_0888);
      irqs.irq_software = 1'b1; irqs.irq_timer = 1'b1; irqs.irq_fast[2] = 1'b1;
      tick(); tick();
      vectors++; if (irq_cause !== 6'h23 || irq_req !== 1'b1) begin miscompares++; $display("FAIL prio_sw: req %0b cause %h want 1/23", irq_req, irq_cause); end
      irq_ack = 1'b1; irqs.irq_software = 1'b0;
      tick();
      irq_ack = 1'b0;
      tick(); tick();
      vectors++; if (irq_cause !== 6'h27 || irq_req !== 1'b1) begin miscompares++; $display("FAIL prio_timer: req %0b cause %h want 1/27", irq_req, irq_cause); end
      irq_ack = 1'b1; irqs.irq_timer = 1'b0;
      tick();
      irq_ack = 1'b0;
      tick(); tick();
      vectors++; if (irq_cause !== 6'h32 || irq_req !== 1'b1) begin miscompares++; $display("FAIL prio_fast2: req %0b cause %h want 1/32", irq_req, irq_cause); end
      irq_ack = 1'b1; irqs.irq_fast[2] = 1'b0;
      tick();
      irq_ack = 1'b0;
      tick(); tick();
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL prio_drained: req got %0b want 0", irq_req); end
   endtask

   task automatic test_withdraw();
      irqs.irq_external = 1'b1;
      tick(); tick();
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL wd_req: req got %0b want 1", irq_req); end
      csr_access(CSR_OP_CLEAR, 12'h304, 32'h0000_0800);
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL wd_w1: req got %0b want 1", irq_req); end
      tick();
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL wd_drop: req got %0b want 0", irq_req); end
      csr_access(CSR_OP_SET, 12'h304, 32'h0000_0800);
      tick();
      vectors++; if (irq_req !== 1'b1 || irq_cause !== 6'h2B) begin miscompares++; $display("FAIL wd_rereq: req %0b cause %h want 1/2b", irq_req, irq_cause); end
      mstatus_mie = 1'b0; irq_ack = 1'b1;
      tick();
      mstatus_mie = 1'b1; irq_ack = 1'b0;
      tick();
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ack_wins_hold: req got %0b want 0", irq_req); end
      tick();
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL ack_wins_req: req got %0b want 1", irq_req); end
      irq_ack = 1'b1; irqs.irq_external = 1'b0;
      tick();
      irq_ack = 1'b0;
      tick(); tick();
   endtask

   task automatic test_nmi();
      mstatus_mie = 1'b0; irq_nm = 1'b1;
      tick(); tick();
      vectors++; if (irq_req !== 1'b1 || irq_cause !== 6'h3F) begin miscompares++; $display("FAIL nmi_req: req %0b cause %h want 1/3f", irq_req, irq_cause); end
      irq_nm = 1'b0;
      tick(); tick();
      vectors++; if (irq_req !== 1'b1 || irq_cause !== 6'h3F) begin miscompares++; $display("FAIL nmi_no_withdraw: req %0b cause %h want 1/3f", irq_req, irq_cause); end
      irq_nm = 1'b1; irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL nmi_hold: req got %0b want 0", irq_req); end
      tick();
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL nmi_gap: req got %0b want 0", irq_req); end
      tick();
      vectors++; if (irq_req !== 1'b1 || irq_cause !== 6'h3F) begin miscompares++; $display("FAIL nmi_second: req %0b cause %h want 1/3f", irq_req, irq_cause); end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      tick(); tick(); tick();
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL nmi_level_no_retrigger: req got %0b want 0", irq_req); end
      irq_nm = 1'b0; mstatus_mie = 1'b1;
      tick();
   endtask

   task automatic test_reset_in_req();
      csr_access(CSR_OP_SET, 12'h304, 32'h0000_0800);
      irqs.irq_external = 1'b1;
      tick(); tick();
      vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre_req: req got %0b want 1", irq_req); end
      rst = 1'b1;
      tick();
      rst = 1'b0; csr_addr = 12'h304; #1;
      vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: req got %0b want 0", irq_req); end
      vectors++; if (csr_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mie: got %h want 0", csr_rdata); end
      irqs = '0;
      tick(); tick();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 600; cyc++) begin
         irqs        = irqs ^ 18'($urandom & $urandom & $urandom);
         irq_nm      = ($urandom_range(0, 7) == 0) ? ~irq_nm : irq_nm;
         mstatus_mie = ($urandom_range(0, 15) == 0) ? ~mstatus_mie : mstatus_mie;
         irq_ack     = ($urandom_range(0, 2) == 0);
         csr_we      = ($urandom_range(0, 3) == 0);
         csr_op      = csr_op_e'($urandom_range(0, 3));
         csr_wdata   = $urandom;
         case ($urandom_range(0, 2))
            0:       csr_addr = 12'h304;
            1:       csr_addr = 12'h344;
            default: csr_addr = 12'($urandom);
         endcase
         rst = ($urandom_range(0, 99) == 0);
         #1;
         vectors++; if (irq_req !== (m_phase == 1)) begin miscompares++; $display("FAIL rand_req cyc %0d: got %0b want %0b", cyc, irq_req, (m_phase == 1)); end
         vectors++; if (irq_cause !== m_cause) begin miscompares++; $display("FAIL rand_cause cyc %0d: got %h want %h", cyc, irq_cause, m_cause); end
         vectors++; if (csr_rdata !== model_rdata(csr_addr)) begin miscompares++; $display("FAIL rand_rdata cyc %0d addr %h: got %h want %h", cyc, csr_addr, csr_rdata, model_rdata(csr_addr)); end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; irqs = '0; irq_nm = 1'b0; mstatus_mie = 1'b0; csr_we = 1'b0;
      csr_op = CSR_OP_READ; csr_addr = 12'h0; csr_wdata = '0; irq_ack = 1'b0;
      tick();
      test_reset();
      test_csr_mask();
      test_external();
      test_priority();
      test_withdraw();
      test_nmi();
      test_reset_in_req();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/irq_pending_arb.md
# irq_pending_arb

Machine-level interrupt front end that sits directly upstream of the trap/exception stage. It registers the raw `irqs_t` request lines into `mip` and holds the software-written `mie` register behind a CSR port driven by `csr_op_e`. It arbitrates the enabled pending interrupts plus an edge-latched NMI into a single `exc_cause_e`, and presents that cause to the trap stage over a req/ack handshake.

## Interface
- `NUM_FAST`, default 15: number of implemented fast interrupts (1..15); `irq_fast[14:NUM_FAST]` is ignored and reads as 0.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `irqs_i`  in  `irqs_t` (18)  level-sensitive software/timer/external/fast requests.
- `irq_nm_i`  in  1  non-maskable interrupt, rising-edge sensitive.
- `mstatus_mie_i`  in  1  global interrupt enable; does not gate NMI.
- `csr_we_i`  in  1  CSR access strobe.
- `csr_op_i`  in  `csr_op_e` (2)  READ/WRITE/SET/CLEAR.
- `csr_addr_i`  in  12  CSR number.
- `csr_wdata_i`  in  32  CSR write operand.
- `csr_rdata_o`  out  32  combinational read data.
- `irq_req_o`  out  1  interrupt request to the trap stage.
- `irq_cause_o`  out  `exc_cause_e` (6)  cause; valid while `irq_req_o`=1.
- `irq_ack_i`  in  1  trap stage has taken the interrupt.

## Operation
- Reset values: `mip`=0, `mie`=0, `nmi_pending`=0, `nm_q`=0, state=IDLE, `irq_req_o`=0, `irq_cause_o`=6'h00.
- `mip` captures `irqs_i` every cycle at bits 3 (SW), 7 (timer), 11 (ext), and 16+i (fast i). All other bits read 0. Writes to `mip` are ignored.
- `mie` is written only when `csr_we_i`=1 and `csr_addr_i`=`CSR_MIE`:
  - WRITE: mie = wdata.
  - SET: mie |= wdata.
  - CLEAR: mie &= ~wdata.
  - READ: no change.
  - The result is always ANDed with `CSR_MIE_MASK`.
- `csr_rdata_o`: `mie` for `CSR_MIE`, `mip` for `CSR_MIP`, 0 for any other address.
- NMI: `nm_q` registers `irq_nm_i`. `irq_nm_i & ~nm_q` sets `nmi_pending`. `nmi_pending` clears only on an ack of an NMI request. If set and clear coincide, set wins.
- Eligible set = (`mip` & `mie` & {32{`mstatus_mie_i`}}), plus `nmi_pending`.
- Priority, highest first: NMI (`EXC_CAUSE_IRQ_NM`), external, software, timer, fast 0, fast 1, …, fast NUM_FAST-1. Fast i encodes as {1'b1, 5'd16+i}.
- State machine:
  - IDLE: if any source is eligible, latch the winning cause and go to REQ.
  - REQ: `irq_req_o`=1, and `irq_cause_o` is frozen even if a higher-priority source arrives.
    - `irq_ack_i`=1: go to HOLD. If the cause is NMI, clear `nmi_pending`.
    - Otherwise, if the latched non-NMI source is no longer eligible (line dropped, `mie` bit cleared, or `mstatus_mie_i`=0), withdraw: go to IDLE with `irq_req_o` low. Ack in the same cycle wins over withdraw.
    - An NMI request is never withdrawn.
  - HOLD: one cycle with `irq_req_o`=0 so the trap stage can clear `mstatus.MIE`; then go to IDLE.
- `irq_ack_i` outside REQ is ignored.
- Reset while in any state returns to IDLE with all reset values on the next edge. Pending NMI edges are lost.

## Timing
- `irqs_i` rises in cycle N → `mip` bit set in N+1 → `irq_req_o` high in N+2 (if enabled).
- `irq_nm_i` rises in cycle N → `nmi_pending` set in N+1 → `irq_req_o` high in N+2.
- Ack in cycle M → `irq_req_o` low in M+1 (HOLD) → earliest new request in M+3.
- A CSR write to `mie` in cycle N affects eligibility from N+1. `csr_rdata_o` reflects the pre-write value in cycle N.
- `irq_req_o` and `irq_cause_o` are registered outputs. `csr_rdata_o` is combinational.

## Structure
- Shared package additions:
  - `irq_arb_state_e` = {IRQ_IDLE, IRQ_REQ, IRQ_HOLD}.
  - `CSR_MIE_MASK` = 32'h7FFF_0888.
  - Reuse the existing `irqs_t`, `exc_cause_e`, `csr_op_e`, `csr_num_e`, and the `CSR_M*IX_BIT` constants.
- One sub-module, `irq_prio_enc`: purely combinational. Inputs are the eligible vector and `nmi_pending`. Outputs are `any_o` and `cause_o`.

## Test plan
- CSR SET of 32'hFFFF_FFFF to `CSR_MIE`, then read → 32'h7FFF_0888. CLEAR of 32'h0000_0080, then read → 32'h7FFF_0808.
- `mie`=0x800, `mstatus_mie_i`=1, `irqs_i.irq_external` pulses high at cycle 10 → `irq_req_o`=1 at cycle 12 with cause {1,11}. Ack at 15 → req low at 16, state IDLE at 17.
- Timer, software, and fast[2] asserted together, all enabled → cause {1,3}. After ack and software drop → {1,7}. After the timer drop → {1,18}.
- External request held in REQ, then `mie` cleared via CSR without ack → `irq_req_o` drops the next cycle. Repeat with ack in the same cycle → HOLD, no withdraw.
- `mstatus_mie_i`=0, `irq_nm_i` rising edge → cause {1,31} two cycles later. A second edge during REQ is latched; after the ack, a second NMI request follows at ack+3.
- Assert `rst_i` for one cycle while in REQ → next cycle `irq_req_o`=0, `mie`=0, `csr_rdata_o` for `CSR_MIE`=0.
